// File: rtl/montgomery_pkg.sv
// montgomery_pkg: shared FSM states and sizing helpers for the digit-serial Montgomery multiplier.
package montgomery_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FINAL, DONE} state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Accumulator width: holds T < 2m plus the radix headroom before the shift
    function automatic int t_width(input int nbits, input int digit);
        return nbits + digit + 2;
    endfunction

endpackage

// File: rtl/montgomery_digit_step.sv
// montgomery_digit_step: one radix-2^DIGIT Montgomery iteration, T' = (T + ai*b + q*m) >> DIGIT.
module montgomery_digit_step
    import montgomery_pkg::*;
#(
    parameter int NBITS = 256,
    parameter int DIGIT = 4,
    localparam int T_W = t_width(NBITS, DIGIT)
) (
    input  logic [T_W-1:0]   t_i,
    input  logic [DIGIT-1:0] ai_i,
    input  logic [NBITS-1:0] b_i,
    input  logic [NBITS-1:0] m_i,
    input  logic [DIGIT-1:0] n0_inv_i,
    output logic [T_W-1:0]   t_o
);

    localparam int SW = T_W + 1;

    logic [DIGIT-1:0] u;
    logic [DIGIT-1:0] q;
    logic [SW-1:0]    sum;

    always_comb begin
        u   = t_i[DIGIT-1:0] + ai_i * b_i[DIGIT-1:0];
        q   = u * n0_inv_i;
        // q is chosen so the low DIGIT bits of sum are zero, making the shift exact
        sum = SW'(t_i) + SW'(ai_i) * SW'(b_i) + SW'(q) * SW'(m_i);
        t_o = T_W'(sum >> DIGIT);
    end

endmodule

// File: rtl/montgomery_mul_radix.sv
// montgomery_mul_radix: digit-serial Montgomery multiply y = a*b*R^-1 mod m, R = 2^(DIGIT*N).
module montgomery_mul_radix
    import montgomery_pkg::*;
#(
    parameter int NBITS = 256,
    parameter int DIGIT = 4,
    parameter int MSZ_W = $clog2(NBITS) + 1,
    localparam int T_W = t_width(NBITS, DIGIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_p,
    input  logic             abort_p,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic [NBITS-1:0] m,
    input  logic [MSZ_W-1:0] m_size,
    input  logic [DIGIT-1:0] n0_inv,
    output logic [NBITS-1:0] y,
    output logic             busy,
    output logic             done_irq_p,
    output logic             err_p
);

    state_e           state_q, state_d;
    logic [NBITS-1:0] a_q, a_d, b_q, b_d, m_q, m_d, y_q, y_d;
    logic [DIGIT-1:0] n0_q, n0_d;
    logic [MSZ_W-1:0] n_q, n_d, i_q, i_d;
    logic [T_W-1:0]   t_q, t_d, t_step;
    logic             err_q, err_d, done_q, done_d, errp_q, errp_d;
    logic             bad;

    montgomery_digit_step #(.NBITS(NBITS), .DIGIT(DIGIT)) u_step (
        .t_i      (t_q),
        .ai_i     (a_q[DIGIT-1:0]),
        .b_i      (b_q),
        .m_i      (m_q),
        .n0_inv_i (n0_q),
        .t_o      (t_step)
    );

    assign bad = (m_size == '0) || (m_size > MSZ_W'(NBITS)) || !m[0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        n0_d    = n0_q;
        n_d     = n_q;
        i_d     = i_q;
        t_d     = t_q;
        y_d     = y_q;
        err_d   = err_q;
        done_d  = 1'b0;
        errp_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // done_q high marks the completion cycle, where a new start is refused
                if (enable_p && !abort_p && !done_q) begin
                    a_d     = a;
                    b_d     = b;
                    m_d     = m;
                    n0_d    = n0_inv;
                    n_d     = MSZ_W'(ceil_div(int'(m_size), DIGIT));
                    i_d     = '0;
                    t_d     = '0;
                    err_d   = bad;
                    state_d = bad ? DONE : CALC;
                end
            end
            CALC: begin
                t_d     = t_step;
                a_d     = a_q >> DIGIT;
                i_d     = i_q + 1'b1;
                state_d = abort_p ? IDLE : (i_q == n_q - 1'b1) ? FINAL : CALC;
            end
            FINAL: begin
                y_d     = abort_p ? y_q : (t_q >= T_W'(m_q)) ? NBITS'(t_q - T_W'(m_q)) : NBITS'(t_q);
                state_d = abort_p ? IDLE : DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                errp_d  = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            n0_q    <= '0;
            n_q     <= '0;
            i_q     <= '0;
            t_q     <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            errp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            n0_q    <= n0_d;
            n_q     <= n_d;
            i_q     <= i_d;
            t_q     <= t_d;
            y_q     <= y_d;
            err_q   <= err_d;
            done_q  <= done_d;
            errp_q  <= errp_d;
        end
    end

    assign y          = y_q;
    assign busy       = (state_q != IDLE);
    assign done_irq_p = done_q;
    assign err_p      = errp_q;

endmodule

// File: doc/montgomery_mul_radix.md
Name: montgomery_mul_radix

Overview:
- Parametrised successor to the bit-serial Montgomery multiplier: digit-serial (radix 2^DIGIT) modular multiply y = a*b*R^-1 mod m.
- Runtime modulus length; R = 2^(DIGIT*N), where N = ceil(m_size/DIGIT).
- Adds busy status, abort, and argument-error reporting.
- Sits under the modular-exponentiation controller as its multiply engine, same enable_p/done_irq_p handshake style.

Parameters:
- NBITS, 256, maximum operand/modulus width.
- DIGIT, 4, bits of a consumed per iteration. Must divide NBITS; legal 1..16.
- MSZ_W, $clog2(NBITS)+1, width of m_size.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable_p  in  1  single-cycle start pulse; operands sampled on the same edge.
- abort_p  in  1  single-cycle abort pulse.
- a  in  NBITS  multiplicand; requires a < m.
- b  in  NBITS  multiplier; requires b < m.
- m  in  NBITS  modulus; must be odd.
- m_size  in  MSZ_W  modulus length in bits, 1..NBITS.
- n0_inv  in  DIGIT  -m^-1 mod 2^DIGIT, precomputed by software.
- y  out  NBITS  result register.
- busy  out  1  high while computing.
- done_irq_p  out  1  one-cycle completion pulse.
- err_p  out  1  one-cycle error pulse, coincident with done_irq_p.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n). Reset clears y=0, busy=0, done_irq_p=0, err_p=0, state=IDLE, T=0 and the digit counter.
- States: IDLE, CALC, FINAL, DONE.
- IDLE with enable_p=1:
  - Latch a, b, m, n0_inv, and N = ceil(m_size/DIGIT).
  - Clear T (width NBITS+DIGIT+2) and digit index i.
  - busy=1; go to CALC.
- Argument check at enable_p: m_size==0, m_size>NBITS, or m[0]==0 is illegal. Illegal arguments go to DONE directly with err_p=1; y is unchanged.
- CALC, one iteration per cycle, with ai = a digit i:
  - q = ((T[DIGIT-1:0] + ai*b[DIGIT-1:0]) * n0_inv) mod 2^DIGIT.
  - T <= (T + ai*b + q*m) >> DIGIT. The low DIGIT bits before the shift are zero by construction.
  - i++. After N iterations go to FINAL.
- FINAL: y <= (T >= m) ? T-m : T, truncated to NBITS. Invariant T < 2m. Go to DONE.
- DONE: done_irq_p=1 for one cycle; busy=0; return to IDLE.
- Latency: done_irq_p high in the cycle after edge N+2, counting the enable_p sampling edge as edge 0. For example, DIGIT=4 with m_size=10 gives N=3, so done is asserted after edge 5.
- Handshake:
  - enable_p while busy=1 is ignored, with no restart and no error.
  - enable_p in the DONE cycle is ignored. A new operation may start in the cycle after done_irq_p.
- Abort:
  - abort_p in CALC or FINAL goes to IDLE next edge, with busy=0, no done_irq_p, and y unchanged.
  - abort_p in IDLE has no effect.
  - abort_p and enable_p together in IDLE: abort wins, no start.
- Reset mid-operation: immediate return to reset values, with no done_irq_p or err_p.
- Input changes: a, b, m, and n0_inv may change after the enable_p edge without affecting the result.
- Caller contract: results for a or b ≥ m are undefined but must still complete in N+2 cycles.

Decomposition:
- montgomery_pkg holds:
  - state enum (IDLE, CALC, FINAL, DONE);
  - function ceil_div(m_size, DIGIT);
  - localparam T_W = NBITS+DIGIT+2.
- Sub-module montgomery_digit_step: combinational q computation and T update for one digit, parameterised by NBITS and DIGIT.
- Top level keeps the FSM, counter, operand registers, and final subtraction.

Test Plan:
- DIGIT=1, a=123, b=456, m=625, m_size=10 -> y=587; done_irq_p 12 cycles after enable_p; err_p=0; busy high throughout.
- DIGIT=4, n0_inv=15, same operands -> y=303; done after edge 5; busy high for 5 cycles.
- DIGIT=4, m=624 (even) or m_size=0 -> err_p and done_irq_p pulse together one cycle after enable_p; y holds the previous value 303.
- DIGIT=4, second enable_p with different operands two cycles into an operation -> ignored; y=303 at the original done time.
- abort_p at cycle 2 of CALC -> busy falls next edge, no done_irq_p. A fresh start with the same operands then yields y=303.
- rst_n asserted mid-CALC -> y=0, busy=0 asynchronously. Random odd m with a,b < m at NBITS=256, DIGIT in {1,4,8,16} -> y matches the reference model a*b*2^-(DIGIT*N) mod m.
